// File: rtl/alu_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : alu_trace_buffer
// Brief    : Captures ALU operations reported by the execute stage while
//            debug is asserted and queues them in a show-ahead FIFO that is
//            drained over a valid/ready read port. Never stalls the core:
//            a capture that finds the FIFO full is dropped and counted.
// Revision : 1.0 - initial release
// ============================================================================
module alu_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SEQ_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              debug,
    input  logic              clear,
    input  logic              alu_valid,
    input  logic [3:0]        alu_ctrl,
    input  logic [31:0]       alu_a,
    input  logic [31:0]       alu_b,
    input  logic [31:0]       alu_result,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [3:0]        rd_ctrl,
    output logic [31:0]       rd_a,
    output logic [31:0]       rd_b,
    output logic [31:0]       rd_result,
    output logic [SEQ_W-1:0]  rd_seq,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [SEQ_W-1:0]  drop_count
);

    // Record layout, MSB to LSB: ctrl | a | b | result | seq
    localparam int                c_REC_W     = 4 + 32 + 32 + 32 + SEQ_W;
    localparam logic [ADDR_W:0]   c_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_PTR_ONE   = (ADDR_W + 1)'(1);
    localparam logic [SEQ_W-1:0]  c_SEQ_ONE   = SEQ_W'(1);
    localparam logic [SEQ_W-1:0]  c_SEQ_MAX   = '1;

    // Pointers carry one extra MSB so full and empty are distinguishable
    logic [ADDR_W:0]      r_wr_ptr;
    logic [ADDR_W:0]      r_rd_ptr;
    logic [SEQ_W-1:0]     r_seq;
    logic                 r_overflow;
    logic [SEQ_W-1:0]     r_drop_count;
    logic [c_REC_W-1:0]   r_mem [DEPTH];

    logic                 w_cap;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [ADDR_W:0]      w_count;
    logic                 w_full;
    logic                 w_empty;
    logic [c_REC_W-1:0]   w_wr_rec;
    logic [c_REC_W-1:0]   w_head;

    // Occupancy and event decode; clear overrides every other event
    always_comb begin
        w_count  = r_wr_ptr - r_rd_ptr;
        w_full   = (w_count == c_DEPTH_CNT);
        w_empty  = (r_wr_ptr == r_rd_ptr);
        w_cap    = debug & alu_valid;
        w_pop    = ~w_empty & rd_ready;
        w_push   = ~clear & w_cap & (~w_full | w_pop);
        w_drop   = ~clear & w_cap & w_full & ~w_pop;
        w_wr_rec = {alu_ctrl, alu_a, alu_b, alu_result, r_seq};
        w_head   = r_mem[r_rd_ptr[ADDR_W-1:0]];
    end

    // Pointer, sequence and drop bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_seq        <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_seq        <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            // Every capture consumes a number, so gaps expose dropped records
            if (w_cap) begin
                r_seq <= r_seq + c_SEQ_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != c_SEQ_MAX) begin
                    r_drop_count <= r_drop_count + c_SEQ_ONE;
                end
            end
        end
    end

    // Record storage; contents are deliberately left untouched by reset/clear
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_wr_rec;
        end
    end

    // Show-ahead read port, forced to zero while nothing is stored
    always_comb begin
        rd_valid  = ~w_empty;
        rd_ctrl   = '0;
        rd_a      = '0;
        rd_b      = '0;
        rd_result = '0;
        rd_seq    = '0;
        if (!w_empty) begin
            {rd_ctrl, rd_a, rd_b, rd_result, rd_seq} = w_head;
        end
    end

    // Status outputs
    always_comb begin
        count      = w_count;
        full       = w_full;
        empty      = w_empty;
        overflow   = r_overflow;
        drop_count = r_drop_count;
    end

endmodule
`default_nettype wire

// File: doc/alu_trace_buffer.md
Name: alu_trace_buffer

Overview:
- Hardware writer side of the ALU result log. Captures every ALU operation the CPU reports while debug is asserted, and buffers each record in a FIFO.
- The FIFO is drained over a valid/ready read port by the simulation log dumper or a host debug link.
- Sits beside the cpu core, fed from the execute stage, and makes the alu_ctrl/a/b/result stream observable without stalling the pipeline.

Parameters:
- DEPTH, 16, number of trace records stored; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointers are ADDR_W+1 bits wide.
- SEQ_W, 16, width of the per-record sequence number and of the drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- debug  input  1  capture enable; when 0, alu_valid is ignored.
- clear  input  1  synchronous flush of FIFO, overflow, drop count and sequence number.
- alu_valid  input  1  execute stage reports one completed ALU op this cycle.
- alu_ctrl  input  4  ALU operation code.
- alu_a  input  32  operand A.
- alu_b  input  32  operand B.
- alu_result  input  32  computed result.
- rd_valid  output  1  head record available (equals !empty).
- rd_ready  input  1  consumer accepts head record.
- rd_ctrl  output  4  head record op code.
- rd_a  output  32  head record operand A.
- rd_b  output  32  head record operand B.
- rd_result  output  32  head record result.
- rd_seq  output  SEQ_W  head record sequence number.
- count  output  ADDR_W+1  records currently stored, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: at least one capture dropped since reset/clear.
- drop_count  output  SEQ_W  dropped captures, saturates at all-ones.

Behaviour:
- Reset (async, reset_n=0):
  - Pointers, count, seq counter, overflow and drop_count all go to 0.
  - empty=1, full=0, rd_valid=0, rd_* data outputs 0.
- Capture event: cap = debug & alu_valid.
- Pop event: pop = rd_valid & rd_ready.
- Push:
  - Condition: cap & (!full | pop). A capture while full is accepted if a pop occurs in the same cycle.
  - Writes {alu_ctrl, alu_a, alu_b, alu_result, seq} at wr_ptr, then increments wr_ptr.
- Sequence counter:
  - Increments on every cap, whether pushed or dropped, and wraps modulo 2^SEQ_W.
  - Gaps in rd_seq therefore reveal dropped records.
- Drop:
  - Condition: cap & full & !pop.
  - The record is discarded, overflow is set to 1, and drop_count increments, holding at 2^SEQ_W-1.
- Read port:
  - Show-ahead. rd_* reflects the entry at rd_ptr combinationally from storage whenever rd_valid=1.
  - rd_* outputs are 0 when empty.
  - rd_ptr advances on pop.
- Latency: a record pushed in cycle N is visible on rd_* with rd_valid=1 in cycle N+1. There is no bypass when empty.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer wrap: pointers are ADDR_W+1 bits; the low ADDR_W bits index storage and the MSB distinguishes full from empty.
- clear:
  - Same-cycle priority over push, pop and drop.
  - Next cycle: empty=1, count=0, overflow=0, drop_count=0, seq=0.
  - Storage contents are not cleared.
- debug deasserted mid-stream: capture stops immediately. Stored records remain readable, and the seq counter holds.
- rd_ready while empty: no effect.
- The block never backpressures the CPU; it has no ready output toward the core.

Test Plan:
- Reset, debug=1, three caps (ctrl=0 a=5 b=3 r=8; ctrl=1 a=5 b=3 r=2; ctrl=2 a=0xF0 b=0x0F r=0) with rd_ready=0 -> count=3, rd_seq=0, rd_result=8; then rd_ready=1 for 3 cycles -> results 8,2,0 with seq 0,1,2, then empty=1.
- 18 consecutive caps with rd_ready=0, DEPTH=16 -> full=1 after 16, overflow=1, drop_count=2; draining yields seq 0..15.
- full, cap and pop in the same cycle -> count stays 16, drop_count unchanged, and the last record read has the new seq.
- debug=0 with alu_valid=1 for 5 cycles -> count=0, seq unaffected; then debug=1 with one cap -> rd_seq equals the prior seq value.
- After overflow, pulse clear concurrently with cap=1 -> next cycle count=0, overflow=0, drop_count=0; the following cap gets seq=0.
- Assert reset_n=0 asynchronously mid-drain with count=7 -> outputs return to reset values without waiting for a clock edge.
